// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Hex glyph table (ABCDEFG, active-high) and scan FSM states.
package seg7_pkg;

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/seg7_hex_encode.sv
// Hex nibble to active-high ABCDEFG glyph.
// Purely combinational; polarity is handled by the caller.
module seg7_hex_encode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with anti-ghost gap,
// frame-synchronous double buffering and leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int GAP_CLKS       = 2,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Data,
    input  logic [NUM_DIGITS-1:0]   i_Dp,
    input  logic                    i_Load,
    input  logic                    i_Lz_Blank,
    output logic [6:0]              o_Segments,
    output logic                    o_Dp,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Done
);

    localparam int MAXC = (CLKS_PER_DIGIT > GAP_CLKS) ? CLKS_PER_DIGIT : GAP_CLKS;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    UNLIT    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);
    localparam state_t        RST_ST   = (GAP_CLKS == 0) ? ST_DRIVE : ST_GAP;

    state_t                st, nxt_st;
    logic [IW-1:0]         idx, nxt_idx;
    logic [CW-1:0]         cnt, nxt_cnt;
    logic                  wrap;
    logic                  pend;
    logic [DW-1:0]         hold, shadow, nxt_sh;
    logic [NUM_DIGITS-1:0] hold_dp, shadow_dp, nxt_sdp;
    logic [IW-1:0]         hi;
    logic                  blank;
    logic [3:0]            nib;
    logic [6:0]            seg_hi, seg_on;
    logic                  dp_on;
    logic                  fd_nxt;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  fd_q;

    // Slot sequencing: GAP then DRIVE per digit, wrap after the last digit
    always_comb begin
        nxt_st  = st;
        nxt_idx = idx;
        nxt_cnt = cnt;
        wrap    = 1'b0;
        unique case (st)
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    nxt_st  = ST_DRIVE;
                    nxt_cnt = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt == CNT_LAST) begin
                    nxt_cnt = '0;
                    nxt_st  = (GAP_CLKS == 0) ? ST_DRIVE : ST_GAP;
                    if (idx == IDX_LAST) begin
                        nxt_idx = '0;
                        wrap    = 1'b1;
                    end else begin
                        nxt_idx = idx + IW'(1);
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign nxt_sh  = (wrap && pend) ? hold : shadow;
    assign nxt_sdp = (wrap && pend) ? hold_dp : shadow_dp;

    // Highest non-zero digit of the value about to be shown
    always_comb begin
        hi = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (nxt_sh[4*k +: 4] != 4'h0) hi = IW'(k);
        end
    end

    assign blank  = i_Lz_Blank && (nxt_idx > hi);
    assign nib    = nxt_sh[{nxt_idx, 2'b00} +: 4];
    assign seg_on = blank ? 7'b0 : seg_hi;
    assign dp_on  = blank ? 1'b0 : nxt_sdp[nxt_idx];
    assign fd_nxt = (nxt_st == ST_DRIVE) && (nxt_idx == IDX_LAST) && (nxt_cnt == CNT_LAST);

    seg7_hex_encode u_enc (
        .nibble (nib),
        .seg    (seg_hi)
    );

    // Scan state plus holding/shadow buffers; a load on the wrap edge waits a frame
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            st        <= RST_ST;
            idx       <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            hold      <= '0;
            hold_dp   <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
        end else begin
            st        <= nxt_st;
            idx       <= nxt_idx;
            cnt       <= nxt_cnt;
            shadow    <= nxt_sh;
            shadow_dp <= nxt_sdp;
            if (wrap && pend) pend <= 1'b0;
            if (i_Load) begin
                hold    <= i_Data;
                hold_dp <= i_Dp;
                pend    <= 1'b1;
            end
        end
    end

    // Outputs registered from next-state so they line up with the current slot
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            seg_q <= UNLIT;
            dp_q  <= ACTIVE_LOW;
            en_q  <= '0;
            fd_q  <= 1'b0;
        end else begin
            fd_q <= fd_nxt;
            if (nxt_st == ST_DRIVE) begin
                en_q  <= EN_ONE << nxt_idx;
                seg_q <= seg_on ^ UNLIT;
                dp_q  <= dp_on ^ ACTIVE_LOW;
            end else begin
                en_q  <= '0;
                seg_q <= UNLIT;
                dp_q  <= ACTIVE_LOW;
            end
        end
    end

    assign o_Segments   = seg_q;
    assign o_Dp         = dp_q;
    assign o_Digit_En   = en_q;
    assign o_Frame_Done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads,
// checked every cycle against a frame-position reference model.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int CPD   = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = GAP + CPD;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   data = '0;
    logic [3:0]    dp = '0;
    logic          load = 1'b0;
    logic          lz = 1'b0;
    logic [6:0]    seg;
    logic          odp;
    logic [3:0]    en;
    logic          fd;

    int compared = 0;
    int mismatched = 0;

    int          m_t;
    logic [15:0] m_sh, m_hold;
    logic [3:0]  m_sdp, m_hdp;
    logic        m_pend, m_lz;
    int          fd_at[$];
    logic        a_seen;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .CLKS_PER_DIGIT (CPD),
        .GAP_CLKS       (GAP),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Data       (data),
        .i_Dp         (dp),
        .i_Load       (load),
        .i_Lz_Blank   (lz),
        .o_Segments   (seg),
        .o_Dp         (odp),
        .o_Digit_En   (en),
        .o_Frame_Done (fd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        m_sh = '0;
        m_hold = '0;
        m_sdp = '0;
        m_hdp = '0;
        m_pend = 1'b0;
        m_lz = 1'b0;
    endtask

    task automatic check_cycle();
        int pos, d, off, hi;
        logic [3:0] e_en;
        logic [6:0] e_seg;
        logic       e_dp;
        pos = m_t % FRAME;
        d   = pos / SLOT;
        off = pos % SLOT;
        hi  = 0;
        for (int k = 0; k < N; k++) if (m_sh[4*k +: 4] != 4'h0) hi = k;
        if (off < GAP) begin
            e_en = 4'b0;
            e_seg = 7'h7f;
            e_dp = 1'b1;
        end else begin
            e_en = 4'(1 << d);
            if (m_lz && d > hi) begin
                e_seg = 7'h7f;
                e_dp = 1'b1;
            end else begin
                e_seg = ~GLYPH[m_sh[4*d +: 4]];
                e_dp = ~m_sdp[d];
            end
        end
        chk("digit_en", 32'(en), 32'(e_en));
        chk("segments", 32'(seg), 32'(e_seg));
        chk("dp", 32'(odp), 32'(e_dp));
        chk("frame_done", 32'(fd), 32'(pos == FRAME - 1));
        chk("onehot0", 32'($countones(en) <= 1), 32'd1);
        if (fd === 1'b1) fd_at.push_back(m_t);
        if (seg === 7'b0001000 && en !== 4'b0) a_seen = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
            m_sh = m_hold;
            m_sdp = m_hdp;
            m_pend = 1'b0;
        end
        if (load) begin
            m_hold = data;
            m_hdp = dp;
            m_pend = 1'b1;
        end
        m_lz = lz;
        m_t++;
        #1;
        load = 1'b0;
        check_cycle();
    endtask

    task automatic run_to(input int p);
        int n = 0;
        while ((m_t % FRAME) != p && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        data = v;
        dp = p;
        load = 1'b1;
        tick();
    endtask

    task automatic chk_unlit(input string tag);
        chk({tag, "_en"}, 32'(en), 32'd0);
        chk({tag, "_seg"}, 32'(seg), 32'h7f);
        chk({tag, "_dp"}, 32'(odp), 32'd1);
        chk({tag, "_fd"}, 32'(fd), 32'd0);
    endtask

    initial begin
        model_reset();
        a_seen = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_unlit("in_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_cycle();

        do_load(16'h1234, 4'b0000);
        run_to(0);
        run_to(1);
        chk("d0_is_4", 32'(seg), 32'h4c);
        chk("d0_en", 32'(en), 32'd1);
        run_to(16);
        chk("d3_is_1", 32'(seg), 32'h4f);

        run_to(2);
        a_seen = 1'b0;
        do_load(16'hAAAA, 4'b0000);
        run_to(6);
        do_load(16'h5555, 4'b0101);
        run_to(0);
        repeat (2 * FRAME) tick();
        chk("no_aaaa", 32'(a_seen), 32'd0);
        run_to(1);
        chk("d0_is_5", 32'(seg), 32'h24);
        chk("frame_period", (fd_at.size() >= 2) ? 32'(fd_at[1] - fd_at[0]) : 32'd0, 32'(FRAME));

        run_to(FRAME - 1);
        chk("wrap_fd", 32'(fd), 32'd1);
        do_load(16'h0009, 4'b0000);
        run_to(1);
        chk("held_old", 32'(seg), 32'h24);
        repeat (FRAME) tick();
        chk("new_after_next", 32'(seg), 32'h04);

        lz = 1'b1;
        do_load(16'h0050, 4'b1001);
        run_to(0);
        run_to(1);
        chk("lz_d0", 32'(seg), 32'h01);
        chk("lz_d0_dp", 32'(odp), 32'd0);
        run_to(6);
        chk("lz_d1", 32'(seg), 32'h24);
        run_to(11);
        chk("lz_d2", 32'(seg), 32'h7f);
        run_to(16);
        chk("lz_d3", 32'(seg), 32'h7f);
        chk("lz_d3_dp", 32'(odp), 32'd1);

        do_load(16'h0000, 4'b0000);
        run_to(0);
        run_to(1);
        chk("zero_d0", 32'(seg), 32'h01);
        run_to(6);
        chk("zero_d1", 32'(seg), 32'h7f);
        run_to(11);
        chk("zero_d2", 32'(seg), 32'h7f);

        do_load(16'h9876, 4'b0110);
        run_to(0);
        run_to(12);
        chk("pre_rst_en", 32'(en), 32'd4);
        #2 rst_n = 1'b0;
        #1 chk_unlit("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_cycle();
        tick();
        chk("post_rst_en", 32'(en), 32'd1);
        chk("post_rst_seg", 32'(seg), 32'h01);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            if ($urandom_range(0, 5) == 0) begin
                data = 16'($urandom);
                dp = 4'($urandom);
                load = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
